// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Writer-side front end of the integer register file. Merges the
//   non-stallable ALU/load result with the handshaked mul/div result into
//   one registered write port, keeps a busy scoreboard of outstanding
//   mul/div destinations, and requests an issue stall when a mul/div
//   result has been refused for STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   alu_valid/alu_rd/alu_data    ALU/load result (no back-pressure)
//   md_issue/md_issue_rd         mul/div instruction issued (sets busy bit)
//   md_valid/md_ready            mul/div result handshake
//   md_rd/md_data                mul/div result destination and data
//   rf_wr_en/rf_rd/rf_wr_data    registered register-file write port
//   busy_vec                     outstanding mul/div destinations
//   stall_req                    freeze issue so mul/div can drain
//
// Starvation FSM
//   state   | meaning
//   ST_IDLE | no mul/div result is being refused
//   ST_WAIT | a pending mul/div result has been refused starve_cnt times

module rf_writeback_arbiter #(
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [$clog2(NUM_REGS)-1:0] alu_rd,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        md_issue,
  input  logic [$clog2(NUM_REGS)-1:0] md_issue_rd,
  input  logic                        md_valid,
  output logic                        md_ready,
  input  logic [$clog2(NUM_REGS)-1:0] md_rd,
  input  logic [DATA_W-1:0]           md_data,
  output logic                        rf_wr_en,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd,
  output logic [DATA_W-1:0]           rf_wr_data,
  output logic [NUM_REGS-1:0]         busy_vec,
  output logic                        stall_req
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]          state, state_nxt;
  logic [CNT_W-1:0]    starve_cnt, starve_cnt_nxt;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                md_accept, md_refuse;

  // ALU has strict priority because its pipeline cannot be stalled.
  assign md_ready  = ~rst & ~alu_valid;
  assign md_accept = md_valid & md_ready;
  assign md_refuse = md_valid & ~md_ready;

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    case (state)
      ST_IDLE: begin
        if (md_refuse) begin
          state_nxt      = ST_WAIT;
          starve_cnt_nxt = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // A dropped md_valid is treated like acceptance: back to idle.
        if (!md_valid || md_accept) begin
          state_nxt      = ST_IDLE;
          starve_cnt_nxt = '0;
        end else if (starve_cnt != CNT_LIMIT) begin
          starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt      = ST_IDLE;
        starve_cnt_nxt = '0;
      end
    endcase
  end

  // Set after clear so a same-cycle re-issue leaves the register busy.
  always_comb begin
    busy_nxt = busy_vec;
    if (md_accept)
      busy_nxt[md_rd] = 1'b0;
    if (md_issue && (md_issue_rd != '0))
      busy_nxt[md_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      busy_vec   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      stall_req  <= (starve_cnt_nxt == CNT_LIMIT);
      busy_vec   <= busy_nxt;
    end
  end

  // Writes to x0 complete their transfer but never strobe the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_rd      <= '0;
      rf_wr_data <= '0;
    end else if (alu_valid) begin
      rf_wr_en   <= (alu_rd != '0);
      rf_rd      <= alu_rd;
      rf_wr_data <= alu_data;
    end else if (md_accept) begin
      rf_wr_en   <= (md_rd != '0);
      rf_rd      <= md_rd;
      rf_wr_data <= md_data;
    end else begin
      rf_wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wr_data;
  logic [31:0] busy_vec;
  logic        stall_req;

  rf_writeback_arbiter #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data),
    .busy_vec(busy_vec), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the write port, scoreboard and stall must show.
  logic        exp_wr_en;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic [31:0] exp_busy;
  int          refusals;   // consecutive refused cycles of the pending result
  logic        exp_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_wr_en = 0; exp_rd = 0; exp_data = 0; exp_busy = 0;
    refusals = 0; exp_stall = 0;
  endtask

  task automatic model_step();
    logic acc;
    acc = md_valid && !alu_valid;
    if (alu_valid) begin
      exp_wr_en = (alu_rd != 0); exp_rd = alu_rd; exp_data = alu_data;
    end else if (acc) begin
      exp_wr_en = (md_rd != 0); exp_rd = md_rd; exp_data = md_data;
    end else begin
      exp_wr_en = 0;
    end
    if (acc) exp_busy[md_rd] = 1'b0;
    if (md_issue && md_issue_rd != 0) exp_busy[md_issue_rd] = 1'b1;
    if (md_valid && alu_valid) refusals = (refusals < LIMIT) ? refusals + 1 : LIMIT;
    else refusals = 0;
    exp_stall = (refusals == LIMIT);
  endtask

  task automatic check_regs();
    chk("rf_wr_en", rf_wr_en, exp_wr_en);
    chk("rf_rd", rf_rd, exp_rd);
    chk("rf_wr_data", rf_wr_data, exp_data);
    chk("busy_vec", busy_vec, exp_busy);
    chk("stall_req", stall_req, exp_stall);
  endtask

  // Inputs are driven just after a falling edge; this checks md_ready,
  // advances the model across the rising edge, and checks registered outputs.
  task automatic cycle();
    #1;
    chk("md_ready", md_ready, !alu_valid);
    model_step();
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    md_issue = 0; md_issue_rd = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    chk("reset_md_ready", md_ready, 1'b0);
    check_regs();
    @(negedge clk);
    rst = 0;

    // ALU write, one-cycle latency, single strobe
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("alu_lit_data", rf_wr_data, 32'hDEADBEEF);
    chk("alu_lit_en", rf_wr_en, 1'b1);
    idle_inputs();
    cycle();
    chk("alu_lit_en_drop", rf_wr_en, 1'b0);

    // mul/div issue to x7, result three cycles later
    md_issue = 1; md_issue_rd = 7;
    cycle();
    chk("busy7_set_lit", busy_vec[7], 1'b1);
    idle_inputs();
    cycle();
    cycle();
    md_valid = 1; md_rd = 7; md_data = 32'h12;
    cycle();
    chk("busy7_clr_lit", busy_vec[7], 1'b0);
    chk("md_wr_lit", {rf_wr_en, rf_rd, rf_wr_data}, {1'b1, 5'd7, 32'h12});
    idle_inputs();
    cycle();

    // Starvation: six refusals, stall from the fourth refusal onward
    md_valid = 1; md_rd = 3; md_data = 32'h55;
    for (int i = 1; i <= 6; i++) begin
      alu_valid = 1; alu_rd = 5'd1 + 5'(i); alu_data = 32'(i);
      cycle();
      chk("stall_lit", stall_req, (i >= 4));
    end
    alu_valid = 0;
    cycle();
    chk("stall_drop_lit", stall_req, 1'b0);
    chk("starve_wr_lit", {rf_wr_en, rf_rd, rf_wr_data}, {1'b1, 5'd3, 32'h55});
    idle_inputs();

    // x0 suppression, both sources
    alu_valid = 1; alu_rd = 0; alu_data = 32'hAAAA;
    cycle();
    chk("alu_x0_lit", rf_wr_en, 1'b0);
    idle_inputs();
    md_valid = 1; md_rd = 0; md_data = 32'hBBBB;
    cycle();
    chk("md_x0_lit", rf_wr_en, 1'b0);
    idle_inputs();

    // Same-cycle issue and accept on x9: set wins
    md_issue = 1; md_issue_rd = 9;
    cycle();
    md_valid = 1; md_rd = 9; md_data = 32'h99;
    cycle();
    chk("busy9_hold_lit", busy_vec[9], 1'b1);
    idle_inputs();
    md_valid = 1; md_rd = 9; md_data = 32'h98;
    cycle();
    chk("busy9_clr_lit", busy_vec[9], 1'b0);
    idle_inputs();

    // Async reset with busy = 0x280, stall asserted and a write in flight
    md_issue = 1; md_issue_rd = 7;
    cycle();
    md_issue_rd = 9;
    cycle();
    md_issue = 0;
    md_valid = 1; md_rd = 7; md_data = 32'h77;
    for (int i = 0; i < LIMIT; i++) begin
      alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hC0DE;
      cycle();
    end
    chk("pre_rst_busy_lit", busy_vec, 32'h0000_0280);
    chk("pre_rst_stall_lit", stall_req, 1'b1);
    chk("pre_rst_wr_lit", rf_wr_en, 1'b1);
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_md_ready", md_ready, 1'b0);
    check_regs();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    alu_valid = 1; alu_rd = 4; alu_data = 32'h4444;
    cycle();
    chk("post_rst_wr_lit", {rf_wr_en, rf_rd, rf_wr_data}, {1'b1, 5'd4, 32'h4444});
    idle_inputs();

    // Randomized traffic obeying the pipeline and handshake obligations
    for (int n = 0; n < 3000; n++) begin
      if (!md_valid) begin
        md_valid = ($urandom_range(0, 2) == 0);
        md_rd = 5'($urandom);
        md_data = $urandom;
      end
      alu_valid = exp_stall ? 1'b0 : ($urandom_range(0, 99) < 60);
      alu_rd = 5'($urandom);
      alu_data = $urandom;
      md_issue = ($urandom_range(0, 3) == 0);
      md_issue_rd = 5'($urandom);
      cycle();
      if (md_valid && !alu_valid) md_valid = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
